regfile_write_arbiter: RTL
==========================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have these parameters:
- DATA_W, 32, write-data width.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of registers covered by the init sweep.

REQ-002 The block SHALL have these ports (clock and reset first):
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has a write pending.
- req0_addr  in  ADDR_W  requester 0 destination register.
- req0_data  in  DATA_W  requester 0 write data.
- req0_ready  out  1  requester 0 write accepted this cycle.
- req1_valid, req1_addr, req1_data, req1_ready  same as requester 0, for requester 1.
- we3  out  1  register file write enable.
- a3  out  ADDR_W  register file write address.
- wd3  out  DATA_W  register file write data.
- init_done  out  1  init sweep finished; arbitration active.
- last_grant  out  1  index of the most recently accepted requester.

Function
REQ-003 The block SHALL implement two states: INIT and ARB.
REQ-004 In INIT, the block SHALL sweep NUM_REGS registers in NUM_REGS cycles:
- we3=1, a3=cnt, wd3=0; cnt increments each cycle.
- req0_ready=0 and req1_ready=0.
REQ-005 When cnt=NUM_REGS-1 in INIT, the block SHALL go to ARB on the next edge and set init_done=1 from that edge onward.
REQ-006 In ARB, readyN SHALL be combinational and asserted only for the granted requester; at most one ready is high per cycle.
REQ-007 Grant rule: one valid requester gets the grant; both valid gives the grant to the requester not equal to last_grant; none valid gives no grant.
REQ-008 A transfer SHALL occur on an edge where reqN_valid and reqN_ready are both high; on that edge, last_grant is set to N.
REQ-009 Latency: on the accept edge, we3/a3/wd3 SHALL register the accepted request, so the register file write happens on the following edge (one-cycle latency).
REQ-010 In any ARB cycle following an edge with no transfer, we3 SHALL be 0; a3 and wd3 SHALL hold their previous values.
REQ-011 Back-to-back transfers SHALL be sustained at one per cycle, with no bubble.
REQ-012 An accepted request with addr=0 SHALL be acknowledged normally but drive we3=0 (write dropped); last_grant still updates.
REQ-013 A requester SHALL hold valid, addr and data stable until it is accepted; the block does not buffer unaccepted requests.

Reset
REQ-014 When rst_n=0, the block SHALL immediately, asynchronously set: we3=0, a3=0, wd3=0, init_done=0, last_grant=1, cnt=0, and state=INIT (or ARB per REQ-017).
REQ-015 A reset asserted mid-sweep or mid-transfer SHALL abort it; the sweep restarts from cnt=0 after release, and any in-flight write is lost.
REQ-016 After rst_n deasserts, the first activity SHALL occur on the first rising clk edge.

Configuration
REQ-017 The macro REGFILE_INIT_SWEEP_EN SHALL control the init sweep:
- Defined: INIT is compiled in; behaviour per REQ-004/005.
- Undefined: no INIT state or counter; reset enters ARB directly, and init_done is tied to 1.
- REQ-005 through REQ-013 SHALL be identical in both builds.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Sweep (macro defined): release reset -> we3=1 with a3=0..31 and wd3=0 over 32 consecutive cycles, then init_done=1 and we3=0.
- Single requester: req0 valid, addr=2, data=40 -> req0_ready=1 that cycle; next cycle we3=1, a3=2, wd3=40; read port 1 at address 2 returns 40 afterwards.
- Contention: both valid (req0 addr=4/80, req1 addr=8/160) on consecutive cycles after reset -> req0 granted first, then req1; we3 high for 2 consecutive cycles with a3=4 then 8.
- Zero register: req1 valid, addr=0, data=20 -> req1_ready=1, we3 stays 0, last_grant=1.
- Reset mid-sweep: assert rst_n=0 at cnt=10 -> we3 falls to 0 immediately; after release, the sweep restarts at a3=0 and takes a full 32 cycles.
- No-init build (macro undefined): release reset -> init_done=1 at once; req0 addr=31, data=640 is accepted on the first edge and written on the next.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Two-requester write arbiter in front of a register-file write port.
// After reset an optional init sweep writes zero to every register; the
// block then arbitrates between two requesters, alternating grants when
// both are valid, and registers the accepted write onto we3/a3/wd3 so
// the register file sees it one cycle after acceptance. Writes to
// register 0 are acknowledged but dropped.
//
// Build option: define REGFILE_INIT_SWEEP_EN to include the INIT sweep
// state and its counter. Without it, reset enters arbitration directly
// and init_done is tied high.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid/addr/data       requester N write request (N = 0, 1)
//   reqN_ready                 requester N accepted this cycle (combinational)
//   we3, a3, wd3               registered register-file write port
//   init_done                  sweep complete, arbitration active
//   last_grant                 index of the most recently accepted requester
module regfile_write_arbiter #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              we3,
   output logic [ADDR_W-1:0] a3,
   output logic [DATA_W-1:0] wd3,
   output logic              init_done,
   output logic              last_grant
);

   logic              arb_active;
   logic              sweep;
   logic [ADDR_W-1:0] sweep_addr;
   logic              grant0;
   logic              grant1;

`ifdef REGFILE_INIT_SWEEP_EN
   typedef enum logic {INIT, ARB} state_t;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] cnt;
   logic [ADDR_W-1:0] cnt_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= INIT;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      arb_active = 1'b0;
      sweep      = 1'b0;
      init_done  = 1'b0;
      case (state)
         INIT: begin
            sweep    = 1'b1;
            cnt_next = cnt + 1'b1;
            if (cnt == ADDR_W'(NUM_REGS - 1)) begin
               state_next = ARB;
               cnt_next   = '0;
            end
         end
         ARB: begin
            arb_active = 1'b1;
            init_done  = 1'b1;
         end
         default: state_next = INIT;
      endcase
   end

   assign sweep_addr = cnt;
`else
   assign arb_active = 1'b1;
   assign sweep      = 1'b0;
   assign sweep_addr = '0;
   assign init_done  = 1'b1;
`endif

   // A lone valid requester wins; under contention the grant goes to the
   // requester that was not served last, giving strict alternation.
   assign grant0 = arb_active && req0_valid && (!req1_valid || last_grant);
   assign grant1 = arb_active && req1_valid && (!req0_valid || !last_grant);

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // Write-port register: sweep writes, accepted requests, or idle.
   // Idle cycles only drop we3 so a3/wd3 keep the last written values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we3        <= 1'b0;
         a3         <= '0;
         wd3        <= '0;
         last_grant <= 1'b1;
      end else if (sweep) begin
         we3 <= 1'b1;
         a3  <= sweep_addr;
         wd3 <= '0;
      end else if (grant0) begin
         we3        <= (req0_addr != '0);
         a3         <= req0_addr;
         wd3        <= req0_data;
         last_grant <= 1'b0;
      end else if (grant1) begin
         we3        <= (req1_addr != '0);
         a3         <= req1_addr;
         wd3        <= req1_data;
         last_grant <= 1'b1;
      end else begin
         we3 <= 1'b0;
      end
   end

endmodule
